// File: rtl/md5_iter_core.sv
// Purpose: iterative single-block MD5 engine that pads a message of up to 16 bytes and hashes it at one step per clock.
// Latency: a request accepted in cycle T gives msg_out_valid in cycle T+66. The next request can be accepted in cycle T+67.
// Backpressure: ready is low while a hash is in flight. msg_in_valid seen while ready is low is dropped, not queued.
// Ports: clk/reset (sync, active-high); msg_in/msg_in_width/msg_in_valid are the request;
//        ready is the idle flag; msg_output/msg_out_valid carry the digest and its one-cycle strobe.
module md5_iter_core #(
   parameter int MAX_BYTES = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] msg_in,
   input  logic [7:0]   msg_in_width,
   input  logic         msg_in_valid,
   output logic         ready,
   output logic [127:0] msg_output,
   output logic         msg_out_valid
);

   typedef enum logic [1:0] {IDLE, PAD, ROUND, DONE} state_t;

   localparam logic [4:0]  MAX_L = 5'(MAX_BYTES);
   localparam logic [7:0]  MAX_W = 8'(8 * MAX_BYTES);
   localparam logic [31:0] IV_A  = 32'h67452301;
   localparam logic [31:0] IV_B  = 32'hefcdab89;
   localparam logic [31:0] IV_C  = 32'h98badcfe;
   localparam logic [31:0] IV_D  = 32'h10325476;

   state_t        state_q, state_d;
   logic [5:0]    step_q, step_d;
   logic [127:0]  msg_q, msg_d;
   logic [4:0]    len_q, len_d;
   logic [31:0]   a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
   logic [31:0]   m_q [16];
   logic [31:0]   m_d [16];
   logic [127:0]  out_q, out_d;

   function automatic logic [31:0] k_rom(input logic [5:0] i);
      case (i)
         6'd0:  k_rom = 32'hd76aa478;  6'd1:  k_rom = 32'he8c7b756;  6'd2:  k_rom = 32'h242070db;  6'd3:  k_rom = 32'hc1bdceee;
         6'd4:  k_rom = 32'hf57c0faf;  6'd5:  k_rom = 32'h4787c62a;  6'd6:  k_rom = 32'ha8304613;  6'd7:  k_rom = 32'hfd469501;
         6'd8:  k_rom = 32'h698098d8;  6'd9:  k_rom = 32'h8b44f7af;  6'd10: k_rom = 32'hffff5bb1;  6'd11: k_rom = 32'h895cd7be;
         6'd12: k_rom = 32'h6b901122;  6'd13: k_rom = 32'hfd987193;  6'd14: k_rom = 32'ha679438e;  6'd15: k_rom = 32'h49b40821;
         6'd16: k_rom = 32'hf61e2562;  6'd17: k_rom = 32'hc040b340;  6'd18: k_rom = 32'h265e5a51;  6'd19: k_rom = 32'he9b6c7aa;
         6'd20: k_rom = 32'hd62f105d;  6'd21: k_rom = 32'h02441453;  6'd22: k_rom = 32'hd8a1e681;  6'd23: k_rom = 32'he7d3fbc8;
         6'd24: k_rom = 32'h21e1cde6;  6'd25: k_rom = 32'hc33707d6;  6'd26: k_rom = 32'hf4d50d87;  6'd27: k_rom = 32'h455a14ed;
         6'd28: k_rom = 32'ha9e3e905;  6'd29: k_rom = 32'hfcefa3f8;  6'd30: k_rom = 32'h676f02d9;  6'd31: k_rom = 32'h8d2a4c8a;
         6'd32: k_rom = 32'hfffa3942;  6'd33: k_rom = 32'h8771f681;  6'd34: k_rom = 32'h6d9d6122;  6'd35: k_rom = 32'hfde5380c;
         6'd36: k_rom = 32'ha4beea44;  6'd37: k_rom = 32'h4bdecfa9;  6'd38: k_rom = 32'hf6bb4b60;  6'd39: k_rom = 32'hbebfbc70;
         6'd40: k_rom = 32'h289b7ec6;  6'd41: k_rom = 32'heaa127fa;  6'd42: k_rom = 32'hd4ef3085;  6'd43: k_rom = 32'h04881d05;
         6'd44: k_rom = 32'hd9d4d039;  6'd45: k_rom = 32'he6db99e5;  6'd46: k_rom = 32'h1fa27cf8;  6'd47: k_rom = 32'hc4ac5665;
         6'd48: k_rom = 32'hf4292244;  6'd49: k_rom = 32'h432aff97;  6'd50: k_rom = 32'hab9423a7;  6'd51: k_rom = 32'hfc93a039;
         6'd52: k_rom = 32'h655b59c3;  6'd53: k_rom = 32'h8f0ccc92;  6'd54: k_rom = 32'hffeff47d;  6'd55: k_rom = 32'h85845dd1;
         6'd56: k_rom = 32'h6fa87e4f;  6'd57: k_rom = 32'hfe2ce6e0;  6'd58: k_rom = 32'ha3014314;  6'd59: k_rom = 32'h4e0811a1;
         6'd60: k_rom = 32'hf7537e82;  6'd61: k_rom = 32'hbd3af235;  6'd62: k_rom = 32'h2ad7d2bb;  default: k_rom = 32'heb86d391;
      endcase
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] w);
      bswap = {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Padded block built from the latched message. The message is first left-justified,
   // so that byte k of the block always comes from the same fixed bit slice.
   logic [7:0]   shift_amt;
   logic [127:0] msg_lj;
   logic [7:0]   pad_byte [64];
   logic [31:0]  pad_word [16];

   always_comb begin
      shift_amt = {5'd16 - len_q, 3'b000};
      msg_lj    = msg_q << shift_amt;
      for (int k = 0; k < 64; k++) pad_byte[k] = 8'h00;
      for (int k = 0; k < 16; k++) begin
         if (5'(k) < len_q) pad_byte[k] = msg_lj[127 - 8*k -: 8];
      end
      pad_byte[{1'b0, len_q}] = 8'h80;
      pad_byte[56]            = {len_q, 3'b000};   // bit length never exceeds 128, so one byte is enough
      for (int j = 0; j < 16; j++)
         pad_word[j] = {pad_byte[4*j+3], pad_byte[4*j+2], pad_byte[4*j+1], pad_byte[4*j]};
   end

   // One MD5 step.
   logic [3:0]  i4, g;
   logic [4:0]  s;
   logic [31:0] f, sum, rot, b_new;
   logic [63:0] dbl;

   always_comb begin
      i4 = step_q[3:0];
      case (step_q[5:4])
         2'd0:    begin f = (b_q & c_q) | (~b_q & d_q); g = i4;                end
         2'd1:    begin f = (d_q & b_q) | (~d_q & c_q); g = i4 * 4'd5 + 4'd1;  end
         2'd2:    begin f = b_q ^ c_q ^ d_q;            g = i4 * 4'd3 + 4'd5;  end
         default: begin f = c_q ^ (b_q | ~d_q);         g = i4 * 4'd7;         end
      endcase
      case ({step_q[5:4], step_q[1:0]})
         4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
         4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
         4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
         4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
      endcase
      sum   = a_q + f + k_rom(step_q) + m_q[g];
      dbl   = {sum, sum} << s;     // upper half is rotl(sum, s)
      rot   = dbl[63:32];
      b_new = b_q + rot;
   end

   // Next state.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      msg_d   = msg_q;
      len_d   = len_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      m_d     = m_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (msg_in_valid) begin
               msg_d   = msg_in;
               len_d   = (msg_in_width > MAX_W) ? MAX_L : msg_in_width[7:3];
               state_d = PAD;
            end
         end
         PAD: begin
            m_d     = pad_word;
            a_d     = IV_A;
            b_d     = IV_B;
            c_d     = IV_C;
            d_d     = IV_D;
            step_d  = 6'd0;
            state_d = ROUND;
         end
         ROUND: begin
            a_d    = d_q;
            d_d    = c_q;
            c_d    = b_q;
            b_d    = b_new;
            step_d = step_q + 6'd1;
            if (step_q == 6'd63) begin
               // The digest register is loaded here so that it is already valid during DONE.
               out_d   = {bswap(d_q + IV_A), bswap(b_new + IV_B), bswap(b_q + IV_C), bswap(c_q + IV_D)};
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         step_q  <= 6'd0;
         msg_q   <= '0;
         len_q   <= 5'd0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         for (int j = 0; j < 16; j++) m_q[j] <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         msg_q   <= msg_d;
         len_q   <= len_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         m_q     <= m_d;
         out_q   <= out_d;
      end
   end

   assign ready         = (state_q == IDLE);
   assign msg_out_valid = (state_q == DONE);
   assign msg_output    = out_q;

endmodule

// File: tb/tb_md5_iter_core.sv
// Purpose: self-checking bench for md5_iter_core. It uses known digests, a reference MD5 function, and random messages.
// Latency: it checks the 66-cycle request-to-strobe and the 67-cycle request-to-request spacing.
// Backpressure: it drives held and dropped requests against ready, and includes reset aborts.
module tb_md5_iter_core;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] msg_in;
   logic [7:0]   msg_in_width;
   logic         msg_in_valid;
   logic         ready;
   logic [127:0] msg_output;
   logic         msg_out_valid;

   md5_iter_core #(.MAX_BYTES(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .msg_in        (msg_in),
      .msg_in_width  (msg_in_width),
      .msg_in_valid  (msg_in_valid),
      .ready         (ready),
      .msg_output    (msg_output),
      .msg_out_valid (msg_out_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference MD5 for a single block. Sine constants come from real arithmetic.
   logic [31:0] kt [64];
   int rot_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

   function automatic int width_to_len(input logic [7:0] w);
      return (w > 8'd128) ? 16 : int'(w) / 8;
   endfunction

   function automatic logic [127:0] md5_model(input logic [127:0] msg, input int nbytes);
      logic [7:0]   blk [64];
      logic [31:0]  w [16];
      logic [31:0]  a, b, c, d, f, t, h [4];
      logic [127:0] res;
      int           g, sh;
      for (int k = 0; k < 64; k++) blk[k] = 8'h00;
      for (int k = 0; k < nbytes; k++) blk[k] = 8'(msg >> (8 * (nbytes - 1 - k)));
      blk[nbytes] = 8'h80;
      blk[56]     = 8'(8 * nbytes);
      for (int j = 0; j < 16; j++) w[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
      a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
      for (int i = 0; i < 64; i++) begin
         case (i / 16)
            0:       begin f = (b & c) | (~b & d); g = i;                end
            1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
         endcase
         sh = rot_tab[(i / 16) * 4 + (i % 4)];
         t  = a + f + kt[i] + w[g];
         t  = (t << sh) | (t >> (32 - sh));
         a  = d; d = c; c = b; b = b + t;
      end
      h[0] = a + 32'h67452301; h[1] = b + 32'hefcdab89;
      h[2] = c + 32'h98badcfe; h[3] = d + 32'h10325476;
      res = '0;
      for (int wi = 0; wi < 4; wi++)
         for (int bi = 0; bi < 4; bi++) res = {res[119:0], h[wi][8*bi +: 8]};
      return res;
   endfunction

   // Issues one request when ready. It waits for the strobe, then checks latency,
   // the digest against the model, and that the strobe lasts one cycle with a held value.
   task automatic do_hash(input logic [127:0] m, input logic [7:0] w, input string tag,
                          output logic [127:0] dig);
      int   t0, waited;
      logic seen;
      logic [127:0] exp;
      exp    = md5_model(m, width_to_len(w));
      waited = 0;
      while (!ready && waited < 200) begin @(negedge clk); waited++; end
      chk({tag, "_rdy"}, ready, 1);
      msg_in       = m;
      msg_in_width = w;
      msg_in_valid = 1'b1;
      t0           = cyc;
      @(negedge clk);
      msg_in_valid = 1'b0;
      msg_in       = {$urandom, $urandom, $urandom, $urandom};
      msg_in_width = 8'($urandom);
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < 200) begin
         if (msg_out_valid) seen = 1'b1;
         else begin @(negedge clk); waited++; end
      end
      chk({tag, "_seen"}, seen, 1);
      chk({tag, "_lat"}, cyc - t0, 66);
      dig = msg_output;
      chk({tag, "_model"}, dig, exp);
      @(negedge clk);
      chk({tag, "_strobe"}, msg_out_valid, 0);
      chk({tag, "_hold"}, msg_output, exp);
   endtask

   localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
   localparam logic [127:0] D_A     = 128'h0cc175b9c0f1b6a831c399e269772661;
   localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
   localparam logic [127:0] D_VADER = 128'h2db1850a4fe292bd2706ffd78dbe44b9;
   localparam logic [127:0] D_MSGD  = 128'hf96b697d7cb7938d525a2f31aaf161d0;

   initial begin
      logic [127:0] dig, d1, d2, m;
      int   t1, o1, o2, acc2, outs, cnt_v, cnt_nr, t0;
      logic drop;
      real  r;

      for (int i = 0; i < 64; i++) begin
         r = $sin(real'(i + 1));
         if (r < 0.0) r = -r;
         kt[i] = 32'(longint'($floor(r * 4294967296.0)));
      end

      reset = 1'b1; msg_in = '0; msg_in_width = '0; msg_in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_ready", ready, 1);
      chk("rst_valid", msg_out_valid, 0);
      chk("rst_out", msg_output, 0);

      // Known vectors.
      do_hash(128'h0, 8'd0, "empty", dig);              chk("empty_known", dig, D_EMPTY);
      do_hash(128'h0 | "a", 8'd8, "a", dig);            chk("a_known", dig, D_A);
      do_hash(128'h0 | "abc", 8'd24, "abc", dig);       chk("abc_known", dig, D_ABC);
      do_hash(128'h0 | "vader", 8'd40, "vader", dig);   chk("vader_known", dig, D_VADER);
      do_hash(128'h0 | "message digest", 8'd112, "msgd", dig); chk("msgd_known", dig, D_MSGD);

      // Back-to-back: valid is held high, and msg_in changes while the core is busy.
      chk("b2b_rdy", ready, 1);
      msg_in = 128'h0 | "a"; msg_in_width = 8'd8; msg_in_valid = 1'b1; t1 = cyc;
      @(negedge clk);
      msg_in = 128'h0 | "abc"; msg_in_width = 8'd24;
      outs = 0; acc2 = 0; o1 = 0; o2 = 0; d1 = '0; d2 = '0; drop = 1'b0;
      for (int n = 0; n < 300 && outs < 2; n++) begin
         if (msg_out_valid) begin
            if (outs == 0) begin o1 = cyc; d1 = msg_output; end
            else begin o2 = cyc; d2 = msg_output; end
            outs++;
         end
         if (ready && msg_in_valid && !drop) begin acc2 = cyc; drop = 1'b1; end
         @(negedge clk);
         if (drop) msg_in_valid = 1'b0;
      end
      chk("b2b_outs", outs, 2);
      chk("b2b_lat1", o1 - t1, 66);
      chk("b2b_acc2", acc2 - t1, 67);
      chk("b2b_gap", o2 - o1, 67);
      chk("b2b_d1", d1, D_A);
      chk("b2b_d2", d2, D_ABC);
      @(negedge clk);

      // Reset at round step 30. The aborted hash must not produce a strobe,
      // and the request that follows immediately must still hash correctly.
      while (!ready) @(negedge clk);
      msg_in = 128'h0 | "vader"; msg_in_width = 8'd40; msg_in_valid = 1'b1; t0 = cyc;
      @(negedge clk);
      msg_in_valid = 1'b0;
      while (cyc < t0 + 32) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_ready", ready, 1);
      do_hash(128'h0 | "abc", 8'd24, "abort_abc", dig);
      chk("abort_abc_known", dig, D_ABC);

      // A request presented together with reset is discarded.
      reset = 1'b1; msg_in = 128'h0 | "a"; msg_in_width = 8'd8; msg_in_valid = 1'b1;
      @(negedge clk);
      reset = 1'b0; msg_in_valid = 1'b0;
      cnt_v = 0; cnt_nr = 0;
      for (int n = 0; n < 80; n++) begin
         if (msg_out_valid) cnt_v++;
         if (!ready) cnt_nr++;
         @(negedge clk);
      end
      chk("rstreq_strobes", cnt_v, 0);
      chk("rstreq_busy", cnt_nr, 0);

      // Width clamping and ignored low bits.
      m = {$urandom, $urandom, $urandom, $urandom};
      do_hash(m, 8'd200, "w200", d1);
      do_hash(m, 8'd128, "w128", d2);
      chk("w200_eq_w128", d1, d2);
      do_hash(128'h0 | "vader", 8'd43, "w43", dig);
      chk("w43_known", dig, D_VADER);

      // Random messages and widths.
      for (int n = 0; n < 10; n++) begin
         m = {$urandom, $urandom, $urandom, $urandom};
         do_hash(m, 8'($urandom_range(0, 255)), $sformatf("rnd%0d", n), dig);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
